// File: rtl/izh_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : izh_ctrl_pkg                                               |
// | Brief   : Shared types for the Izhikevich step controller: the        |
// |           controller state encoding and the spike-event record.     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package izh_ctrl_pkg;

    // Default widths of the event record fields (step counter, core word)
    localparam int DEF_CNT_W = 16;
    localparam int DEF_N     = 24;

    // Controller sequence: IDLE -> INIT -> RUN -> DRAIN -> DONE -> IDLE
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_t;

    // One queued spike: step index it occurred on, plus the core's last_dv
    typedef struct packed {
        logic [DEF_CNT_W-1:0] step;
        logic [DEF_N-1:0]     dv;
    } spike_evt_t;

endpackage
`default_nettype wire

// File: rtl/izhikevich_step_controller_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spike_event_fifo                                           |
// | Brief   : Synchronous first-word-fall-through FIFO, async reset.     |
// |           A push into a full FIFO is accepted only when a pop        |
// |           happens in the same cycle.                                 |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module spike_event_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    // Pointers carry one extra wrap bit to tell full from empty
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // On a full FIFO the write lands in the slot the pop is vacating
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero when empty so stale storage never leaks out
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; pointers wrap naturally modulo 2*DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because dout is gated by empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/izhikevich_step_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : izhikevich_step_controller                                 |
// | Brief   : Sequences one Izhikevich core: init pulse, then a run of   |
// |           apply pulses at a programmable cadence, sampling the       |
// |           core's spike flag one cycle after each apply and queueing  |
// |           spiking step indices into an event FIFO.                   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module izhikevich_step_controller
    import izh_ctrl_pkg::*;
#(
    parameter int N     = 24,
    parameter int CNT_W = 16,
    parameter int DIV_W = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] num_steps,
    input  logic [DIV_W-1:0] step_div,
    output logic             core_rst,
    output logic             core_apply,
    input  logic             core_is_spiking,
    input  logic [N-1:0]     core_last_dv,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_step,
    output logic [N-1:0]     evt_dv,
    output logic [CNT_W-1:0] spike_count,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    // Event record sized to this instance's parameters
    typedef struct packed {
        logic [CNT_W-1:0] step;
        logic [N-1:0]     dv;
    } evt_t;

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;

    logic [CNT_W-1:0] steps_lat;      // run length latched at start
    logic [DIV_W-1:0] div_lat;        // cadence latched at start
    logic [CNT_W-1:0] step_idx;       // index carried by the next apply
    logic [DIV_W-1:0] div_cnt;        // idle cycles left before next apply
    logic             sample_pending; // an apply was issued last cycle
    logic [CNT_W-1:0] sample_idx;     // step index of that apply

    logic             start_accept;
    logic             last_step;
    logic             spike_hit;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    evt_t             fifo_din;
    evt_t             fifo_dout;

    assign start_accept = (state == ST_IDLE) && start;
    assign last_step    = (step_idx == (steps_lat - CNT_ONE));
    // The core's registered outputs are valid the cycle after the apply
    assign spike_hit    = sample_pending && core_is_spiking;
    assign fifo_pop     = evt_ready && !fifo_empty;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and core-facing strobes; stop suppresses an apply in its own cycle
    always_comb begin
        state_nxt  = state;
        core_rst   = 1'b0;
        core_apply = 1'b0;
        done       = 1'b0;
        busy       = (state != ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_INIT;
            end
            ST_INIT: begin
                core_rst = 1'b1;
                if (stop)                 state_nxt = ST_IDLE;
                else if (steps_lat == '0) state_nxt = ST_DONE;
                else                      state_nxt = ST_RUN;
            end
            ST_RUN: begin
                core_apply = (div_cnt == '0) && !stop;
                if (stop)                        state_nxt = ST_IDLE;
                else if (core_apply && last_step) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Run configuration, step counter and cadence divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            steps_lat <= '0;
            div_lat   <= '0;
            step_idx  <= '0;
            div_cnt   <= '0;
        end else if (start_accept) begin
            steps_lat <= num_steps;
            div_lat   <= step_div;
            step_idx  <= '0;
            div_cnt   <= '0;
        end else if (core_apply) begin
            step_idx  <= step_idx + CNT_ONE;
            div_cnt   <= div_lat;
        end else if ((state == ST_RUN) && (div_cnt != '0)) begin
            div_cnt   <= div_cnt - DIV_ONE;
        end
    end

    // Remember which step the core will report on next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_pending <= 1'b0;
            sample_idx     <= '0;
        end else begin
            sample_pending <= core_apply;
            sample_idx     <= step_idx;
        end
    end

    // Spike statistics: saturating count and sticky drop flag, cleared per run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_count <= '0;
            overflow    <= 1'b0;
        end else if (start_accept) begin
            spike_count <= '0;
            overflow    <= 1'b0;
        end else if (spike_hit) begin
            if (spike_count != '1) spike_count <= spike_count + CNT_ONE;
            if (fifo_full && !fifo_pop) overflow <= 1'b1;
        end
    end

    assign fifo_din.step = sample_idx;
    assign fifo_din.dv   = core_last_dv;

    spike_event_fifo #(
        .WIDTH ($bits(evt_t)),
        .DEPTH (DEPTH)
    ) u_evt_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (spike_hit),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_step  = fifo_dout.step;
    assign evt_dv    = fifo_dout.dv;

endmodule
`default_nettype wire

// File: tb/tb_izhikevich_step_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_izhikevich_step_controller                              |
// | Brief   : Self-checking bench with a behavioural core stub and an    |
// |           expected-event scoreboard.                                 |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_izhikevich_step_controller;
    import izh_ctrl_pkg::*;

    localparam int N     = 24;
    localparam int CNT_W = 16;
    localparam int DIV_W = 8;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] num_steps;
    logic [DIV_W-1:0] step_div;
    logic             core_rst;
    logic             core_apply;
    logic             core_is_spiking;
    logic [N-1:0]     core_last_dv;
    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W-1:0] evt_step;
    logic [N-1:0]     evt_dv;
    logic [CNT_W-1:0] spike_count;
    logic             busy;
    logic             done;
    logic             overflow;

    int n_checks = 0;
    int n_errors = 0;

    izhikevich_step_controller #(
        .N (N), .CNT_W (CNT_W), .DIV_W (DIV_W), .DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .num_steps       (num_steps),
        .step_div        (step_div),
        .core_rst        (core_rst),
        .core_apply      (core_apply),
        .core_is_spiking (core_is_spiking),
        .core_last_dv    (core_last_dv),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_step        (evt_step),
        .evt_dv          (evt_dv),
        .spike_count     (spike_count),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- core stub ----------------
    int spike_mode = 0;   // 0: never, 1: only step 2, 2: every step
    int stub_cnt;

    function automatic bit stub_spikes(input int s);
        case (spike_mode)
            1:       return (s == 2);
            2:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [N-1:0] stub_dv(input int s);
        logic [7:0] mid;
        mid = 8'(s + 8);
        return {8'h00, mid, 8'h00};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_is_spiking <= 1'b0;
            core_last_dv    <= '0;
            stub_cnt        <= 0;
        end else if (core_rst) begin
            core_is_spiking <= 1'b0;
            core_last_dv    <= '0;
            stub_cnt        <= 0;
        end else if (core_apply) begin
            core_is_spiking <= stub_spikes(stub_cnt);
            core_last_dv    <= stub_dv(stub_cnt);
            stub_cnt        <= stub_cnt + 1;
        end
    end

    // ---------------- monitors ----------------
    int cyc = 0;
    int apply_total = 0;
    int done_total = 0;
    int rst_total = 0;
    int pop_total = 0;
    int valid_total = 0;
    int last_rst_cyc = 0;
    int last_done_cyc = 0;
    int overlap_seen = 0;
    int apply_cyc[$];
    spike_evt_t exp_q[$];

    always @(negedge clk) begin
        spike_evt_t e;
        cyc++;
        if (core_apply) begin
            apply_total++;
            apply_cyc.push_back(cyc);
        end
        if (core_rst) begin
            rst_total++;
            last_rst_cyc = cyc;
        end
        if (done) begin
            done_total++;
            last_done_cyc = cyc;
        end
        if (core_rst && core_apply) overlap_seen++;
        if (evt_valid) valid_total++;
        if (evt_valid && evt_ready) begin
            pop_total++;
            if (exp_q.size() == 0) begin
                check("evt_unexpected", 64'(evt_step), 64'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("evt_step", 64'(evt_step), 64'(e.step));
                check("evt_dv", 64'(evt_dv), 64'(e.dv));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_run(input int ns, input int sd);
        @(posedge clk); #1;
        num_steps = CNT_W'(ns);
        step_div  = DIV_W'(sd);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic drain_fifo(input int budget, input string tag);
        int n = 0;
        evt_ready = 1'b1;
        while (evt_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        evt_ready = 1'b0;
        check(tag, 64'(evt_valid), 64'd0);
    endtask

    initial begin
        int ab, at, dt, rt, pt, vt, n;
        rst = 1'b1; start = 1'b0; stop = 1'b0; evt_ready = 1'b0;
        num_steps = '0; step_div = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_outs", 64'({core_rst, core_apply, evt_valid, done, overflow}), 0);
        check("rst_count", 64'(spike_count), 0);
        rst = 1'b0;

        // ---- run 1: 5 steps, div 2, no spikes ----
        spike_mode = 0;
        ab = apply_cyc.size(); dt = done_total; rt = rst_total; vt = valid_total;
        start_run(5, 2);
        wait_idle(200, "r1_timeout");
        check("r1_applies", 64'(apply_cyc.size() - ab), 5);
        check("r1_core_rst", 64'(rst_total - rt), 1);
        if (apply_cyc.size() - ab == 5) begin
            check("r1_first_apply", 64'(apply_cyc[ab] - last_rst_cyc), 1);
            for (int i = 1; i < 5; i++)
                check("r1_cadence", 64'(apply_cyc[ab+i] - apply_cyc[ab]), 64'(3*i));
            check("r1_done_time", 64'(last_done_cyc - apply_cyc[ab+4]), 2);
        end
        check("r1_done", 64'(done_total - dt), 1);
        check("r1_no_valid", 64'(valid_total - vt), 0);
        check("r1_spikes", 64'(spike_count), 0);

        // ---- run 2: 4 steps back to back, spike on step 2 ----
        spike_mode = 1;
        exp_q.push_back('{step: 16'd2, dv: 24'h000A00});
        at = apply_total; dt = done_total;
        start_run(4, 0);
        wait_idle(100, "r2_timeout");
        check("r2_applies", 64'(apply_total - at), 4);
        check("r2_done", 64'(done_total - dt), 1);
        check("r2_spikes", 64'(spike_count), 1);
        check("r2_valid", 64'(evt_valid), 1);
        check("r2_overflow", 64'(overflow), 0);
        drain_fifo(20, "r2_drain_timeout");
        check("r2_sb_empty", 64'(exp_q.size()), 0);

        // ---- run 3: 12 spiking steps into an 8-deep FIFO, no consumer ----
        spike_mode = 2;
        for (int i = 0; i < DEPTH; i++)
            exp_q.push_back('{step: 16'(i), dv: stub_dv(i)});
        start_run(12, 0);
        wait_idle(100, "r3_timeout");
        check("r3_overflow", 64'(overflow), 1);
        check("r3_spikes", 64'(spike_count), 12);
        pt = pop_total;
        drain_fifo(40, "r3_drain_timeout");
        check("r3_pops", 64'(pop_total - pt), DEPTH);
        check("r3_sb_empty", 64'(exp_q.size()), 0);

        // ---- run 4: long run stopped in RUN cycle 20 ----
        spike_mode = 2;
        evt_ready = 1'b1;
        for (int i = 0; i < 20; i++)
            exp_q.push_back('{step: 16'(i), dv: stub_dv(i)});
        at = apply_total; dt = done_total;
        start_run(100, 0);
        n = 0;
        while ((apply_total - at) < 20 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("r4_reach_timeout", 64'(apply_total - at), 20);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check("r4_busy_fall", 64'(busy), 0);
        repeat (6) @(posedge clk);
        #1;
        check("r4_applies", 64'(apply_total - at), 20);
        check("r4_no_done", 64'(done_total - dt), 0);
        check("r4_spikes", 64'(spike_count), 20);
        check("r4_overflow", 64'(overflow), 0);
        check("r4_sb_empty", 64'(exp_q.size()), 0);
        evt_ready = 1'b0;

        // ---- run 5: async reset mid-run with three queued events ----
        spike_mode = 2;
        at = apply_total;
        start_run(100, 3);
        n = 0;
        while ((apply_total - at) < 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("r5_queued", 64'(spike_count), 3);
        check("r5_valid", 64'(evt_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("r5_rst_busy", 64'(busy), 0);
        check("r5_rst_outs", 64'({core_rst, core_apply, evt_valid, done, overflow}), 0);
        check("r5_rst_evt", 64'({evt_step, evt_dv}), 0);
        check("r5_rst_count", 64'(spike_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("r5_fifo_empty", 64'(evt_valid), 0);

        // ---- run 6: zero-length run ----
        spike_mode = 0;
        at = apply_total; dt = done_total; rt = rst_total;
        start_run(0, 0);
        wait_idle(20, "r6_timeout");
        check("r6_applies", 64'(apply_total - at), 0);
        check("r6_done", 64'(done_total - dt), 1);
        check("r6_core_rst", 64'(rst_total - rt), 1);
        check("r6_done_time", 64'(last_done_cyc - last_rst_cyc), 1);

        check("rst_apply_excl", 64'(overlap_seen), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
